// File: rtl/csr_trap_unit_pkg.sv
// Shared constants for the machine-mode CSR file and trap sequencer:
// CSR indices, op encodings, cause codes, field positions and FSM states.
package csr_trap_unit_pkg;

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MISA      = 12'h301;
   localparam logic [11:0] CSR_MIE       = 12'h304;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MIP       = 12'h344;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MVENDORID = 12'hF11;
   localparam logic [11:0] CSR_MARCHID   = 12'hF12;
   localparam logic [11:0] CSR_MIMPID    = 12'hF13;
   localparam logic [11:0] CSR_MHARTID   = 12'hF14;

   typedef enum logic [1:0] {
      OP_NONE = 2'b00,
      OP_RW   = 2'b01,
      OP_RS   = 2'b10,
      OP_RC   = 2'b11
   } csr_op_e;

   localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
   localparam logic [3:0] CAUSE_BREAK   = 4'd3;
   localparam logic [3:0] CAUSE_ECALL   = 4'd11;
   localparam logic [3:0] CAUSE_MSI     = 4'd3;
   localparam logic [3:0] CAUSE_MTI     = 4'd7;
   localparam logic [3:0] CAUSE_MEI     = 4'd11;

   localparam int unsigned MSI_BIT  = 3;
   localparam int unsigned MTI_BIT  = 7;
   localparam int unsigned MEI_BIT  = 11;
   localparam int unsigned MIE_BIT  = 3;
   localparam int unsigned MPIE_BIT = 7;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_WAIT = 1'b1
   } state_e;

   typedef enum logic [1:0] {
      CLS_NONE = 2'd0,
      CLS_RO   = 2'd1,
      CLS_RW   = 2'd2
   } csr_cls_e;

   function automatic csr_cls_e csr_class(input logic [11:0] idx);
      case (idx)
         CSR_MISA, CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MHARTID: return CLS_RO;
         CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
         CSR_MCAUSE, CSR_MIP, CSR_MCYCLE, CSR_MINSTRET:                 return CLS_RW;
         default:                                                       return CLS_NONE;
      endcase
   endfunction

   // Spread a {meip, mtip, msip} triple onto its architectural bit positions.
   function automatic logic [11:0] irq_map(input logic [2:0] v);
      return {v[2], 3'b000, v[1], 3'b000, v[0], 3'b000};
   endfunction

endpackage

// File: rtl/csr_trap_unit_irq_arb.sv
// Interrupt arbiter: registers the irq levels into mip, qualifies them with
// mie/MIE and picks the highest-priority cause (MEI > MSI > MTI).
module csr_irq_arb
   import csr_trap_unit_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       irq_mtip,
   input  logic       irq_msip,
   input  logic       irq_meip,
   input  logic [2:0] mie_en,
   input  logic       glb_ie,
   output logic [2:0] pend,
   output logic       int_pend_c,
   output logic [3:0] int_cause_c,
   output logic [5:0] vec_off_c
);

   logic [2:0] active;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) pend <= 3'b000;
      else      pend <= {irq_meip, irq_mtip, irq_msip};
   end

   always_comb begin
      active      = pend & mie_en;
      int_pend_c  = glb_ie & (|active);
      int_cause_c = 4'd0;
      if (active[2])      int_cause_c = CAUSE_MEI;
      else if (active[0]) int_cause_c = CAUSE_MSI;
      else if (active[1]) int_cause_c = CAUSE_MTI;
      vec_off_c   = {int_cause_c, 2'b00};
   end

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with trap/interrupt sequencing and a redirect handshake.
// Optional macro CSR_VECTORED_EN enables vectored mtvec mode (mtvec[1:0]=01).
module csr_trap_unit
   import csr_trap_unit_pkg::*;
#(
   parameter int unsigned     XLEN      = 64,
   parameter int unsigned     CNT_W     = 64,
   parameter logic [XLEN-1:0] HART_ID   = '0,
   parameter logic [XLEN-1:0] MTVEC_RST = '0
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            inst_valid,
   output logic            commit_ready,
   input  logic [11:0]     csr_index,
   input  logic [1:0]      csr_op,
   input  logic [XLEN-1:0] csr_wdata,
   input  logic [XLEN-1:0] inst_addr,
   input  logic            inst_ecall,
   input  logic            inst_ebreak,
   input  logic            inst_mret,
   input  logic            irq_mtip,
   input  logic            irq_msip,
   input  logic            irq_meip,
   output logic [XLEN-1:0] csr_read,
   output logic            csr_illegal,
   output logic            redirect_valid,
   input  logic            redirect_ready,
   output logic [XLEN-1:0] redirect_pc
);

`ifdef CSR_VECTORED_EN
   localparam bit VEC_EN = 1'b1;
`else
   localparam bit VEC_EN = 1'b0;
`endif

   localparam logic [XLEN-1:0] MISA_VAL =
      (XLEN'(XLEN == 64 ? 2 : 1) << (XLEN - 2)) | XLEN'(32'h100);

   state_e            state;
   logic              mst_mie, mst_mpie;
   logic [XLEN-1:0]   mtvec, mepc, mcause, mscratch;
   logic [2:0]        mie_en, mip_q;
   logic [CNT_W-1:0]  mcycle, minstret;

   logic              int_pend_c;
   logic [3:0]        int_cause_c;
   logic [5:0]        vec_off_c;

   logic              hs, take_int, trap, do_mret, do_wr, retire;
   logic [3:0]        cause;
   logic [XLEN-1:0]   wval, trap_pc;

   csr_irq_arb u_irq_arb (
      .clk         (clk),
      .rst         (rst),
      .irq_mtip    (irq_mtip),
      .irq_msip    (irq_msip),
      .irq_meip    (irq_meip),
      .mie_en      (mie_en),
      .glb_ie      (mst_mie),
      .pend        (mip_q),
      .int_pend_c  (int_pend_c),
      .int_cause_c (int_cause_c),
      .vec_off_c   (vec_off_c)
   );

   // Old-value read mux; unknown indices read as zero.
   always_comb begin
      csr_read = '0;
      case (csr_index)
         CSR_MSTATUS:   csr_read = XLEN'(13'h1800) | (XLEN'(mst_mpie) << MPIE_BIT)
                                   | (XLEN'(mst_mie) << MIE_BIT);
         CSR_MISA:      csr_read = MISA_VAL;
         CSR_MIE:       csr_read = XLEN'(irq_map(mie_en));
         CSR_MIP:       csr_read = XLEN'(irq_map(mip_q));
         CSR_MTVEC:     csr_read = mtvec;
         CSR_MSCRATCH:  csr_read = mscratch;
         CSR_MEPC:      csr_read = mepc;
         CSR_MCAUSE:    csr_read = mcause;
         CSR_MCYCLE:    csr_read = XLEN'(mcycle);
         CSR_MINSTRET:  csr_read = XLEN'(minstret);
         CSR_MARCHID:   csr_read = XLEN'(1);
         CSR_MHARTID:   csr_read = HART_ID;
         default:       csr_read = '0;
      endcase
   end

   // Event priority: interrupt > illegal > ecall > ebreak > mret > CSR write.
   always_comb begin
      csr_illegal = (csr_op != OP_NONE) && (csr_class(csr_index) != CLS_RW);
      hs          = inst_valid & commit_ready;
      take_int    = hs & int_pend_c;
      trap        = take_int | (hs & (csr_illegal | inst_ecall | inst_ebreak));
      retire      = hs & ~trap;
      do_mret     = retire & inst_mret;
      do_wr       = retire & ~inst_mret & (csr_op != OP_NONE);

      cause = CAUSE_BREAK;
      if (take_int)         cause = int_cause_c;
      else if (csr_illegal) cause = CAUSE_ILLEGAL;
      else if (inst_ecall)  cause = CAUSE_ECALL;

      case (csr_op)
         OP_RW:   wval = csr_wdata;
         OP_RS:   wval = csr_read | csr_wdata;
         OP_RC:   wval = csr_read & ~csr_wdata;
         default: wval = csr_read;
      endcase

      trap_pc = {mtvec[XLEN-1:2], 2'b00}
              + ((VEC_EN && take_int && mtvec[0]) ? XLEN'(vec_off_c) : '0);
   end

   // CSR state; later assignments (explicit counter writes) win over increments.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mst_mie  <= 1'b0;
         mst_mpie <= 1'b0;
         mtvec    <= {MTVEC_RST[XLEN-1:2], 2'b00};
         mepc     <= '0;
         mcause   <= '0;
         mie_en   <= 3'b000;
         mscratch <= '0;
         mcycle   <= '0;
         minstret <= '0;
      end else begin
         mcycle <= mcycle + CNT_W'(1);
         if (retire) minstret <= minstret + CNT_W'(1);
         if (trap) begin
            mepc     <= inst_addr;
            mcause   <= {take_int, (XLEN-1)'(cause)};
            mst_mpie <= mst_mie;
            mst_mie  <= 1'b0;
         end else if (do_mret) begin
            mst_mie  <= mst_mpie;
            mst_mpie <= 1'b1;
         end else if (do_wr) begin
            case (csr_index)
               CSR_MSTATUS: begin
                  mst_mie  <= wval[MIE_BIT];
                  mst_mpie <= wval[MPIE_BIT];
               end
               CSR_MTVEC:    mtvec <= VEC_EN ? {wval[XLEN-1:2], 1'b0, wval[1:0] == 2'b01}
                                             : {wval[XLEN-1:2], 2'b00};
               CSR_MEPC:     mepc <= {wval[XLEN-1:2], 2'b00};
               CSR_MCAUSE:   mcause <= wval;
               CSR_MIE:      mie_en <= {wval[MEI_BIT], wval[MTI_BIT], wval[MSI_BIT]};
               CSR_MSCRATCH: mscratch <= wval;
               CSR_MCYCLE:   mcycle <= CNT_W'(wval);
               CSR_MINSTRET: minstret <= CNT_W'(wval);
               default: ;
            endcase
         end
      end
   end

   // Redirect sequencer: stalls commit until fetch accepts the new PC.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= ST_RUN;
         commit_ready   <= 1'b1;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
      end else begin
         case (state)
            ST_RUN: begin
               if (trap || do_mret) begin
                  redirect_pc    <= trap ? trap_pc : mepc;
                  redirect_valid <= 1'b1;
                  commit_ready   <= 1'b0;
                  state          <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (redirect_ready) begin
                  redirect_valid <= 1'b0;
                  commit_ready   <= 1'b1;
                  state          <= ST_RUN;
               end
            end
            default: state <= ST_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Bench for csr_trap_unit (XLEN=32, CNT_W=16): directed scenarios then random
// traffic, all checked against an architectural reference model.
module tb_csr_trap_unit;

   localparam logic [11:0] I_MSTATUS = 12'h300, I_MISA = 12'h301, I_MIE = 12'h304,
                           I_MTVEC = 12'h305, I_MSCRATCH = 12'h340, I_MEPC = 12'h341,
                           I_MCAUSE = 12'h342, I_MIP = 12'h344, I_MCYCLE = 12'hB00,
                           I_MINSTRET = 12'hB02, I_MHARTID = 12'hF14;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_valid, commit_ready;
   logic [11:0] csr_index;
   logic [1:0]  csr_op;
   logic [31:0] csr_wdata, inst_addr, csr_read, redirect_pc;
   logic        inst_ecall, inst_ebreak, inst_mret;
   logic        irq_mtip, irq_msip, irq_meip;
   logic        csr_illegal, redirect_valid, redirect_ready;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state, kept as whole architectural register values.
   logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause, m_mie, m_mip, m_mscratch, m_rpc;
   logic [15:0] m_mcycle, m_minstret;
   logic        m_wait;

   logic [11:0] idx_tab [16] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                 12'h342, 12'h344, 12'hB00, 12'hB02, 12'hF11, 12'hF12,
                                 12'hF13, 12'hF14, 12'h7C0, 12'h000};

   csr_trap_unit #(.XLEN(32), .CNT_W(16), .HART_ID(32'd5), .MTVEC_RST(32'h103)) dut (
      .clk(clk), .rst(rst), .inst_valid(inst_valid), .commit_ready(commit_ready),
      .csr_index(csr_index), .csr_op(csr_op), .csr_wdata(csr_wdata), .inst_addr(inst_addr),
      .inst_ecall(inst_ecall), .inst_ebreak(inst_ebreak), .inst_mret(inst_mret),
      .irq_mtip(irq_mtip), .irq_msip(irq_msip), .irq_meip(irq_meip),
      .csr_read(csr_read), .csr_illegal(csr_illegal), .redirect_valid(redirect_valid),
      .redirect_ready(redirect_ready), .redirect_pc(redirect_pc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit m_known(input logic [11:0] idx);
      for (int k = 0; k < 14; k++) if (idx_tab[k] == idx) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit m_legal(input logic [11:0] idx, input logic [1:0] op);
      bit ro;
      ro = (idx == I_MISA) || (idx >= 12'hF11 && idx <= 12'hF14);
      return (op == 2'b00) || (m_known(idx) && !ro);
   endfunction

   function automatic logic [31:0] m_read(input logic [11:0] idx);
      case (idx)
         I_MSTATUS:  return m_mstatus;
         I_MISA:     return 32'h4000_0100;
         I_MIE:      return m_mie;
         I_MTVEC:    return m_mtvec;
         I_MSCRATCH: return m_mscratch;
         I_MEPC:     return m_mepc;
         I_MCAUSE:   return m_mcause;
         I_MIP:      return m_mip;
         I_MCYCLE:   return {16'h0, m_mcycle};
         I_MINSTRET: return {16'h0, m_minstret};
         12'hF12:    return 32'd1;
         I_MHARTID:  return 32'd5;
         default:    return 32'd0;
      endcase
   endfunction

   task automatic model_reset();
      m_mstatus = 32'h1800; m_mtvec = 32'h100; m_mepc = 0; m_mcause = 0;
      m_mie = 0; m_mip = 0; m_mscratch = 0; m_mcycle = 0; m_minstret = 0;
      m_wait = 0; m_rpc = 0;
   endtask

   // One clock of architectural behaviour given the currently driven inputs.
   task automatic model_tick();
      int unsigned prio [3] = '{11, 3, 7};
      logic [31:0] old, wv, target;
      logic [15:0] ncyc, nret;
      logic [3:0]  cause;
      bit hs, pend, trap, go_mret, is_int;
      int unsigned ic;
      hs   = inst_valid && !m_wait;
      pend = m_mstatus[3] && ((m_mip & m_mie) != 0);
      ic = 0;
      for (int k = 0; k < 3; k++) if (ic == 0 && m_mip[prio[k]] && m_mie[prio[k]]) ic = prio[k];
      old = m_read(csr_index);
      case (csr_op)
         2'b01:   wv = csr_wdata;
         2'b10:   wv = old | csr_wdata;
         2'b11:   wv = old & ~csr_wdata;
         default: wv = old;
      endcase
      trap = 0; go_mret = 0; is_int = 0; cause = 0; target = 0;
      ncyc = m_mcycle + 16'd1;
      nret = m_minstret;
      if (hs) begin
         if (pend) begin trap = 1; is_int = 1; cause = ic[3:0]; end
         else if (!m_legal(csr_index, csr_op)) begin trap = 1; cause = 4'd2; end
         else if (inst_ecall) begin trap = 1; cause = 4'd11; end
         else if (inst_ebreak) begin trap = 1; cause = 4'd3; end
         else begin
            nret = nret + 16'd1;
            if (inst_mret) go_mret = 1;
            else if (csr_op != 2'b00) begin
               case (csr_index)
                  I_MSTATUS:  m_mstatus = 32'h1800 | (wv & 32'h88);
                  I_MIE:      m_mie = wv & 32'h888;
`ifdef CSR_VECTORED_EN
                  I_MTVEC:    m_mtvec = (wv & ~32'h3) | ((wv[1:0] == 2'b01) ? 32'h1 : 32'h0);
`else
                  I_MTVEC:    m_mtvec = wv & ~32'h3;
`endif
                  I_MSCRATCH: m_mscratch = wv;
                  I_MEPC:     m_mepc = wv & ~32'h3;
                  I_MCAUSE:   m_mcause = wv;
                  I_MCYCLE:   ncyc = wv[15:0];
                  I_MINSTRET: nret = wv[15:0];
                  default: ;
               endcase
            end
         end
      end
      if (trap) begin
         target = m_mtvec & ~32'h3;
`ifdef CSR_VECTORED_EN
         if (is_int && m_mtvec[1:0] == 2'b01) target = target + 4 * 32'(cause);
`endif
         m_mepc    = inst_addr;
         m_mcause  = {is_int, 27'd0, cause};
         m_mstatus = 32'h1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
      end else if (go_mret) begin
         target    = m_mepc;
         m_mstatus = 32'h1880 | (m_mstatus[7] ? 32'h8 : 32'h0);
      end
      if (m_wait) begin
         if (redirect_ready) m_wait = 0;
      end else if (trap || go_mret) begin
         m_wait = 1; m_rpc = target;
      end
      m_mcycle   = ncyc;
      m_minstret = nret;
      m_mip      = (32'(irq_meip) << 11) | (32'(irq_mtip) << 7) | (32'(irq_msip) << 3);
   endtask

   task automatic step();
      @(negedge clk);
      check("csr_read", csr_read, m_read(csr_index));
      check("csr_illegal", csr_illegal, !m_legal(csr_index, csr_op));
      check("commit_ready", commit_ready, !m_wait);
      check("redirect_valid", redirect_valid, m_wait);
      check("redirect_pc", redirect_pc, m_rpc);
      model_tick();
      @(posedge clk); #1;
   endtask

   task automatic idle();
      inst_valid = 0; csr_op = 0; csr_wdata = 0;
      inst_ecall = 0; inst_ebreak = 0; inst_mret = 0;
   endtask

   task automatic issue(input logic [11:0] idx, input logic [1:0] op, input logic [31:0] wd,
                        input logic [31:0] pc, input logic ec, input logic mr);
      csr_index = idx; csr_op = op; csr_wdata = wd; inst_addr = pc;
      inst_ecall = ec; inst_mret = mr; inst_ebreak = 0; inst_valid = 1;
      step();
      idle();
   endtask

   task automatic rd(input logic [11:0] idx, input logic [31:0] exp, input string tag);
      idle();
      csr_index = idx;
      #1;
      check(tag, csr_read, exp);
      step();
   endtask

   task automatic drain();
      redirect_ready = 1;
      idle();
      for (int i = 0; i < 20 && m_wait; i++) step();
      check("drain_done", redirect_valid, 1'b0);
   endtask

   initial begin
      logic [15:0] save;
      rst = 0; redirect_ready = 1; csr_index = 0; inst_addr = 0;
      irq_mtip = 0; irq_msip = 0; irq_meip = 0;
      idle();
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1;

      rd(I_MSTATUS, 32'h1800, "rst_mstatus");
      rd(I_MHARTID, 32'd5, "mhartid");

      csr_index = I_MISA; csr_op = 2'b01; csr_wdata = 32'h1234; inst_addr = 32'h40;
      inst_valid = 1;
      #1 check("misa_illegal", csr_illegal, 1'b1);
      step();
      idle();
      check("misa_redir_valid", redirect_valid, 1'b1);
      check("misa_redir_pc", redirect_pc, 32'h100);
      drain();
      rd(I_MCAUSE, 32'd2, "misa_mcause");
      rd(I_MEPC, 32'h40, "misa_mepc");

      issue(I_MSCRATCH, 2'b01, 32'h0F, 32'h44, 0, 0);
      issue(I_MSCRATCH, 2'b10, 32'hF0, 32'h48, 0, 0);
      rd(I_MSCRATCH, 32'hFF, "mscratch_rs");
      issue(I_MSCRATCH, 2'b11, 32'h0F, 32'h4C, 0, 0);
      rd(I_MSCRATCH, 32'hF0, "mscratch_rc");

      // Timer interrupt with a stalled redirect.
      issue(I_MIE, 2'b01, 32'h80, 32'h50, 0, 0);
      issue(I_MSTATUS, 2'b10, 32'h8, 32'h54, 0, 0);
      save = m_minstret;
      irq_mtip = 1; redirect_ready = 0;
      step();
      issue(I_MSCRATCH, 2'b00, 0, 32'h8000_0010, 0, 0);
      irq_mtip = 0;
      for (int i = 0; i < 3; i++) begin
         csr_index = I_MSCRATCH; csr_op = 2'b01; csr_wdata = 32'hDEAD; inst_valid = 1;
         step();
         check("hold_valid", redirect_valid, 1'b1);
         check("hold_pc", redirect_pc, 32'h100);
         check("hold_commit_ready", commit_ready, 1'b0);
      end
      drain();
      rd(I_MCAUSE, 32'h8000_0007, "mti_mcause");
      rd(I_MEPC, 32'h8000_0010, "mti_mepc");
      rd(I_MSTATUS, 32'h1880, "mti_mstatus");
      rd(I_MINSTRET, {16'h0, save}, "mti_minstret");
      rd(I_MSCRATCH, 32'hF0, "mti_no_write");

      // Simultaneous external and timer interrupt.
      issue(I_MIE, 2'b01, 32'h880, 32'h60, 0, 0);
      issue(I_MTVEC, 2'b01, 32'h1001, 32'h64, 0, 0);
      issue(I_MSTATUS, 2'b10, 32'h8, 32'h68, 0, 0);
      irq_meip = 1; irq_mtip = 1;
      step();
      issue(I_MSCRATCH, 2'b00, 0, 32'h8000_0020, 0, 0);
`ifdef CSR_VECTORED_EN
      check("mei_vec_pc", redirect_pc, 32'h102C);
`else
      check("mei_base_pc", redirect_pc, 32'h1000);
`endif
      irq_meip = 0; irq_mtip = 0;
      drain();
      rd(I_MCAUSE, 32'h8000_000B, "mei_mcause");

      issue(I_MCYCLE, 2'b01, 32'hFFFF, 32'h70, 0, 0);
      rd(I_MCYCLE, 32'hFFFF, "mcycle_max");
      rd(I_MCYCLE, 32'h0, "mcycle_wrap");

      save = m_minstret;
      issue(12'h000, 2'b00, 0, 32'h200, 1, 0);
      drain();
      rd(I_MINSTRET, {16'h0, save}, "ecall_minstret");
      rd(I_MCAUSE, 32'd11, "ecall_mcause");
      issue(12'h000, 2'b00, 0, 32'h300, 0, 1);
      check("mret_pc", redirect_pc, 32'h200);
      drain();
      rd(I_MINSTRET, {16'h0, save + 16'd1}, "mret_minstret");

      // Reset while a redirect is outstanding.
      issue(12'h000, 2'b00, 0, 32'h400, 1, 0);
      check("pre_rst_valid", redirect_valid, 1'b1);
      rst = 0;
      #1;
      check("async_rst_valid", redirect_valid, 1'b0);
      check("async_rst_ready", commit_ready, 1'b1);
      model_reset();
      @(posedge clk); #1 rst = 1;
      rd(I_MTVEC, 32'h100, "rst_mtvec");
      rd(I_MSTATUS, 32'h1800, "rst_mstatus2");
      for (int k = 0; k < 16; k++) rd(idx_tab[k], m_read(idx_tab[k]), "rst_csr");

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         csr_index      = idx_tab[$urandom_range(0, 15)];
         csr_op         = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
         csr_wdata      = $urandom;
         inst_addr      = $urandom & ~32'h3;
         inst_valid     = ($urandom_range(0, 9) < 7);
         inst_ecall     = ($urandom_range(0, 19) == 0);
         inst_ebreak    = ($urandom_range(0, 19) == 0);
         inst_mret      = ($urandom_range(0, 19) == 0);
         redirect_ready = $urandom_range(0, 1) == 1;
         if ($urandom_range(0, 9) == 0) irq_mtip = ~irq_mtip;
         if ($urandom_range(0, 9) == 0) irq_msip = ~irq_msip;
         if ($urandom_range(0, 9) == 0) irq_meip = ~irq_meip;
         step();
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/csr_trap_unit.md
Name: csr_trap_unit

Overview:
- Parametrised machine-mode CSR file with an integrated trap/interrupt sequencer.
- Sits beside the commit stage. Executes CSR read/modify/write at commit and takes prioritised interrupts and exceptions.
- Issues the redirect PC through a valid/ready handshake and stalls commit until the fetch unit accepts it.
- Adds width parameters, three interrupt sources with priority, illegal-CSR detection and a registered redirect FSM.

Parameters:
XLEN, 64, data/address width (32 or 64)
CNT_W, 64, mcycle/minstret counter width (1..XLEN); reads zero-extended to XLEN
HART_ID, 0, value returned by mhartid
MTVEC_RST, 0, mtvec reset value (bits[1:0] forced to 0)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
inst_valid  in  1  committing instruction present
commit_ready  out  1  commit accepted this cycle; handshake = inst_valid & commit_ready
csr_index  in  12  CSR address
csr_op  in  2  00 none, 01 RW, 10 RS, 11 RC
csr_wdata  in  XLEN  rs1 value or zero-extended immediate, selected upstream
inst_addr  in  XLEN  PC of the committing instruction
inst_ecall  in  1  ecall
inst_ebreak  in  1  ebreak
inst_mret  in  1  mret
irq_mtip  in  1  timer interrupt level
irq_msip  in  1  software interrupt level
irq_meip  in  1  external interrupt level
csr_read  out  XLEN  old CSR value (combinational)
csr_illegal  out  1  current csr_op/csr_index is illegal (combinational)
redirect_valid  out  1  redirect_pc is valid
redirect_ready  in  1  fetch unit accepts the redirect
redirect_pc  out  XLEN  trap vector or mepc

Behaviour:
- Supported CSRs:
  - Read-only: misa, mvendorid (0), marchid (1), mimpid (0), mhartid (HART_ID).
  - Read-write: mstatus, mtvec, mepc, mcause, mie, mip, mscratch, mcycle, minstret.
- Illegal: csr_op != 00 with an unknown index, or RW/RS/RC to a read-only index. Raises csr_illegal and an exception with cause 2. No CSR is written.
- Write value: RW = wdata; RS = old | wdata; RC = old & ~wdata. Writes happen only on the handshake.
- Field masks:
  - mstatus: only MIE[3] and MPIE[7] writable; MPP[12:11] reads 2'b11.
  - mie: bits 3, 7, 11 writable.
  - mip: MSIP[3], MTIP[7], MEIP[11] are read-only, registered copies of irq_* (one-cycle latency); writes are ignored.
  - mtvec: bits[1:0] written as 0.
  - mepc: bits[1:0] written as 0.
- Interrupt pending: int_pend = mstatus.MIE & |(mip & mie).
- Event priority on a handshake cycle:
  1. interrupt (MEI 11 > MSI 3 > MTI 7)
  2. illegal (2)
  3. ecall (11)
  4. ebreak (3)
  5. mret
  6. CSR write
- Trap entry:
  - mepc <= inst_addr; mcause <= {is_int, cause}; MPIE <= MIE; MIE <= 0.
  - The trapping instruction is not retired: no CSR write, no minstret increment.
- mret: MIE <= MPIE; MPIE <= 1; redirect to mepc. mret counts as retired.
- Trap target is mtvec base.
- Counters:
  - mcycle increments every cycle; minstret increments on each retired handshake.
  - A CSR write to a counter wins over its increment that cycle.
  - Counters wrap from 2^CNT_W-1 to 0.
- FSM:
  - RUN: commit_ready=1. On a trap or mret handshake, register redirect_pc, set redirect_valid=1, go to WAIT.
  - WAIT: commit_ready=0; redirect_valid and redirect_pc held stable until redirect_ready, then back to RUN with redirect_valid=0. Minimum one cycle in WAIT.
  - Interrupts arriving in WAIT stay pending in mip; they are evaluated on the next RUN handshake.
- Reset (asynchronous, active-low):
  - mstatus=0x1800; mtvec=MTVEC_RST; mepc, mcause, mie, mip, mscratch, mcycle, minstret = 0.
  - FSM=RUN; redirect_valid=0; redirect_pc=0.
  - Reset asserted in WAIT drops redirect_valid immediately.

Optional Feature:
CSR_VECTORED_EN:
- Defined: mtvec[1:0] writable with values 00 or 01 (a write of 1x stores 00). In mode 01, interrupts target base + 4*cause; exceptions target base.
- Undefined: mtvec[1:0] is hardwired to 00 and all traps target base.

Decomposition:
- Shared package/defines header holds:
  - CSR index constants.
  - csr_op encodings.
  - Cause codes (2, 3, 7, 11) and interrupt bit positions.
  - mstatus field positions.
  - FSM state encoding.
- One natural sub-module: csr_irq_arb. It registers irq_*, computes int_pend and the prioritised cause, and returns the vectored offset.

Test Plan:
- Reset, then read mstatus -> 0x1800; read mhartid -> HART_ID; RW to misa -> csr_illegal=1, mcause=2, mepc=inst_addr, redirect to mtvec.
- RS mscratch with 0xF0 after RW 0x0F -> read 0xFF; RC with 0x0F -> 0xF0.
- mie=0x80, MIE=1, irq_mtip=1 with inst_addr=0x8000_0010:
  - mcause = 2^(XLEN-1)+7, mepc=0x8000_0010, MIE=0, MPIE=1, minstret unchanged.
  - Hold redirect_ready=0 for 3 cycles -> redirect_valid and redirect_pc stable, commit_ready=0.
- irq_meip and irq_mtip raised in the same cycle, both enabled -> mcause low bits = 11; with CSR_VECTORED_EN and mtvec=0x1001 -> redirect_pc=0x102C.
- Write mcycle=2^CNT_W-1 -> next cycle reads 0. Retiring ecall -> minstret not incremented. mret -> incremented, redirect_pc=mepc.
- Assert rst in WAIT -> redirect_valid=0 asynchronously; after release, FSM is in RUN and all CSRs are at reset values.
